// File: rtl/sat_fifo_pkg.sv
// Shared types and constants for the SAT clause-stream FIFO front end.
package sat_fifo_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_push_arbiter_rr_prio_pick.sv
// Rotating-priority picker: returns the first asserted request at or after
// base, wrapping modulo N. Purely combinational.
module rr_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] base,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW:0] cand;

    // Walk from the farthest candidate down to base so the nearest hit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, base} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Burst-aware round-robin arbiter merging N_SRC producers into one sfifo push
// port; each pushed word is tagged with the id of the source it came from.
module fifo_push_arbiter
    import sat_fifo_pkg::*;
#(
    parameter  int N_SRC = 4,
    parameter  int WIDTH = 32,
    localparam int SRC_W = $clog2(N_SRC),
    localparam int OUT_W = SRC_W + WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_last,
    output logic [N_SRC-1:0]       src_ready,
    output logic                   fifo_push,
    output logic [OUT_W-1:0]       fifo_push_data,
    input  logic                   fifo_full,
    input  logic                   flush,
    output logic                   busy,
    output logic [SRC_W-1:0]       owner,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_next;
    logic [SRC_W-1:0] owner_next;
    logic [SRC_W-1:0] gnt;
    logic             grant_valid;
    logic             accept;
    logic             stall_inc;
    logic             pick_any;
    logic [SRC_W-1:0] pick_idx;
    logic [WIDTH-1:0] src_words [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_split
        assign src_words[i] = src_data[i*WIDTH +: WIDTH];
    end

    rr_prio_pick #(
        .N (N_SRC)
    ) u_pick (
        .req  (src_valid),
        .base (rr_ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign busy = (state == ARB_LOCKED);

    // The grant is recomputed every cycle and never latched, so a full FIFO
    // simply holds everything in place. Outputs are gated by rst_n so the
    // push port is quiet the instant reset asserts.
    always_comb begin
        gnt            = pick_idx;
        grant_valid    = pick_any;
        if (state == ARB_LOCKED) begin
            gnt         = owner;
            grant_valid = src_valid[owner];
        end
        accept         = grant_valid & ~fifo_full & ~flush & rst_n;
        stall_inc      = grant_valid & fifo_full & ~flush;
        fifo_push      = accept;
        src_ready      = accept ? (N_SRC'(1) << gnt) : '0;
        fifo_push_data = {gnt, src_words[gnt]};

        state_next     = state;
        rr_next        = rr_ptr;
        owner_next     = owner;
        if (flush) begin
            state_next = ARB_IDLE;
            rr_next    = '0;
            owner_next = '0;
        end else if (accept) begin
            if (src_last[gnt]) begin
                state_next = ARB_IDLE;
                rr_next    = (gnt == SRC_W'(N_SRC - 1)) ? '0 : gnt + 1'b1;
            end else begin
                state_next = ARB_LOCKED;
                owner_next = gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_next;
            owner  <= owner_next;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
